// File: rtl/load_store_unit.sv
// Load/store unit: turns an effective address, store data and f3 into one
// multi-cycle req/ack data-memory transaction. It returns aligned,
// sign- or zero-extended load data and stalls the core until the access ends.
// Misaligned accesses, illegal f3 values and bus timeouts abort the access
// with a one-cycle fault pulse.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_size;
  logic               r_uns;
  logic [1:0]         r_off;
  logic               r_we;
  logic [31:0]        r_read_data;
  logic               r_fault;
  logic [1:0]         r_fault_code;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [31:0]        r_bus_addr;
  logic [3:0]         r_bus_wstrb;
  logic [31:0]        r_bus_wdata;

  logic               w_legal;
  logic               w_misal;
  logic [3:0]         w_wstrb;
  logic [31:0]        w_wdata;

  // Pick the addressed byte or halfword from the read word and extend it.
  function automatic logic [31:0] f_extract(input logic [31:0] rdata,
                                            input logic [1:0]  size,
                                            input logic        uns,
                                            input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   f_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   f_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: f_extract = rdata;
    endcase
  endfunction

  // Decode legality and alignment of the requested access.
  always_comb begin
    w_legal = 1'b0;
    w_misal = 1'b0;
    if (mem_we) begin
      w_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      w_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
    end
    if (f3[1:0] == 2'b01) begin
      w_misal = addr[0];
    end else if (f3[1:0] == 2'b10) begin
      w_misal = (addr[1:0] != 2'b00);
    end
  end

  // Byte strobes and lane-replicated store data for the access size.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = wdata;
    case (f3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Stall while a request is being accepted or the bus access is in flight.
  always_comb begin
    stall = 1'b0;
    if (r_state == S_IDLE) begin
      stall = mem_req;
    end else if (r_state == S_BUS) begin
      stall = 1'b1;
    end
  end

  // Access state machine with registered bus, fault and load-result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_we         <= 1'b0;
      r_read_data  <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wstrb  <= 4'b0000;
      r_bus_wdata  <= '0;
    end else begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            if (!w_legal) begin
              r_state      <= S_ERR;
              r_fault      <= 1'b1;
              r_fault_code <= 2'b11;
            end else if (w_misal) begin
              r_state      <= S_ERR;
              r_fault      <= 1'b1;
              r_fault_code <= 2'b01;
            end else begin
              r_size      <= f3[1:0];
              r_uns       <= f3[2];
              r_off       <= addr[1:0];
              r_we        <= mem_we;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= mem_we;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_wstrb <= mem_we ? w_wstrb : 4'b0000;
              r_bus_wdata <= w_wdata;
              r_state     <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // An ack in the last allowed cycle still completes the access.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_we) begin
              r_read_data <= f_extract(bus_rdata, r_size, r_uns, r_off);
            end
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_bus_req    <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= 2'b10;
            r_state      <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_data  = r_read_data;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed accesses plus randomized accesses
// checked against a behavioural model of the memory-access rules.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;
  logic [1:0]  fault_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .f3(f3),
    .addr(addr), .wdata(wdata), .read_data(read_data), .stall(stall),
    .fault(fault), .fault_code(fault_code), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic we, input logic [2:0] f);
    int v;
    v = int'(f);
    if (we) return (v <= 2);
    return (v <= 2) || (v == 4) || (v == 5);
  endfunction

  function automatic int nbytes(input logic [2:0] f);
    return 1 << int'(f[1:0]);
  endfunction

  // Reference: shift the addressed bytes down, mask to size, extend as needed.
  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [1:0] off,
                                             input logic [31:0] word);
    longint unsigned v, mask;
    int nb;
    nb = nbytes(f);
    if (nb == 4) return word;
    v    = longint'(word) >> (8 * int'(off));
    mask = (64'd1 << (8 * nb)) - 1;
    v    = v & mask;
    if (!f[2] && v >= (mask + 1) / 2) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] wd);
    case (nbytes(f))
      1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // One access. Entered and left just after a rising edge with the unit idle.
  task automatic access(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] word);
    int  code;
    int  nb;
    bit  acked;
    logic [3:0] estrb;
    nb = nbytes(f);
    if (!is_legal(we, f)) code = 3;
    else if ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00)) code = 1;
    else code = 0;
    mem_req = 1'b1; mem_we = we; f3 = f; addr = a; wdata = wd;
    @(negedge clk);
    chk("stall_on_request", stall, 1);
    @(posedge clk); #1;
    mem_req = 1'b0;
    if (code != 0) begin
      @(negedge clk);
      chk("err_fault", fault, 1);
      chk("err_code", fault_code, code);
      chk("err_no_bus_req", bus_req, 0);
      chk("err_stall", stall, 0);
      chk("err_read_data", read_data, exp_rd);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fault_pulse_end", fault, 0);
      chk("fault_code_clear", fault_code, 0);
      @(posedge clk); #1;
      return;
    end
    estrb = we ? 4'(((1 << nb) - 1) << int'(a[1:0])) : 4'b0000;
    acked = 0;
    for (int k = 1; k <= TO && !acked; k++) begin
      @(negedge clk);
      chk("bus_req_high", bus_req, 1);
      chk("bus_stall", stall, 1);
      chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("bus_we", bus_we, we);
      chk("bus_wstrb", bus_wstrb, estrb);
      if (we) chk("bus_wdata", bus_wdata, model_wdata(f, wd));
      chk("bus_no_fault", fault, 0);
      if (k - 1 == waits) begin
        bus_ack = 1'b1; bus_rdata = word; acked = 1;
      end else begin
        bus_rdata = $urandom;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    @(negedge clk);
    chk("post_bus_req_low", bus_req, 0);
    chk("post_stall_low", stall, 0);
    if (acked) begin
      if (!we) exp_rd = model_load(f, a[1:0], word);
      chk("done_no_fault", fault, 0);
      chk("done_read_data", read_data, exp_rd);
      @(posedge clk); #1;
    end else begin
      chk("timeout_fault", fault, 1);
      chk("timeout_code", fault_code, 2);
      chk("timeout_read_data", read_data, exp_rd);
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = $urandom;
      @(negedge clk);
      chk("late_ack_bus_req", bus_req, 0);
      chk("late_ack_stall", stall, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_read_data", read_data, exp_rd);
      chk("late_ack_no_fault", fault, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; f3 = 3'b000; addr = '0;
    wdata = '0; bus_ack = 1'b0; bus_rdata = '0; exp_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_read_data", read_data, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wstrb", bus_wstrb, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_stall", stall, 0);
    @(posedge clk); #1;

    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_value", read_data, 32'hDEADBEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000);
    chk("lb_value", read_data, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000);
    chk("lbu_value", read_data, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h80FF_0000);
    chk("lh_value", read_data, 32'hFFFF_80FF);
    access(1'b1, 3'b000, 32'h201, 32'h1234_56AB, 0, 32'h5555_5555);
    chk("sb_keeps_read_data", read_data, 32'hFFFF_80FF);
    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    access(1'b1, 3'b001, 32'h305, 32'h0, 0, 32'h0);
    access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    access(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    access(1'b0, 3'b010, 32'h400, 32'h0, 99, 32'h0);
    access(1'b0, 3'b010, 32'h404, 32'h0, TO - 1, 32'hCAFE_F00D);
    chk("ack_last_cycle_value", read_data, 32'hCAFE_F00D);

    // Reset in the middle of a waited bus access.
    mem_req = 1'b1; mem_we = 1'b0; f3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    chk("midbus_rst_bus_req", bus_req, 0);
    chk("midbus_rst_stall", stall, 0);
    chk("midbus_rst_read_data", read_data, 0);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("midbus_rst_ack_ignored", read_data, 0);
    chk("midbus_rst_ack_no_req", bus_req, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
             int'($urandom_range(0, TO + 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("rand_idle_stall", stall, 0);
        chk("rand_idle_bus_req", bus_req, 0);
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
